// File: rtl/output_buffer_if.sv
// rtl/output_buffer_if.sv - collect/drain handshake bundle between PE array, host and output buffer
interface output_buffer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  output_buffer_enable;
  logic                  pe_result_valid;
  logic [DATA_WIDTH-1:0] pe_result_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  frame_done;

  // Control unit / PE array / host side
  modport master (
    output output_buffer_enable, pe_result_valid, pe_result_data, rd_en,
    input  rd_data, rd_valid, full, empty, count, overflow, frame_done
  );

  // Buffer side
  modport slave (
    input  output_buffer_enable, pe_result_valid, pe_result_data, rd_en,
    output rd_data, rd_valid, full, empty, count, overflow, frame_done
  );
endinterface

// File: rtl/output_buffer.sv
// rtl/output_buffer.sv - PE-array result FIFO with IDLE/COLLECT/DRAIN framing; OUTPUT_BUFFER_RELU_EN stores negative words as zero
module output_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  output_buffer_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  w_frame_done_next;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic                  r_full;
  logic                  r_empty;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_overflow;
  logic                  r_frame_done;

  logic                  w_in_collect;
  logic                  w_wr_ok;
  logic                  w_wr_drop;
  logic                  w_rd_ok;
  logic [CW-1:0]         w_count_next;
  logic [DATA_WIDTH-1:0] w_wr_word;

  // A full FIFO drops the incoming word even if a read frees a slot on the same edge
  assign w_in_collect = (r_state == COLLECT);
  assign w_wr_ok      = w_in_collect && bus.pe_result_valid && !r_full;
  assign w_wr_drop    = w_in_collect && bus.pe_result_valid &&  r_full;
  assign w_rd_ok      = bus.rd_en && !r_empty;
  assign w_count_next = r_count + CW'(w_wr_ok) - CW'(w_rd_ok);

`ifdef OUTPUT_BUFFER_RELU_EN
  assign w_wr_word = bus.pe_result_data[DATA_WIDTH-1] ? '0 : bus.pe_result_data;
`else
  assign w_wr_word = bus.pe_result_data;
`endif

  // State register and frame_done pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_frame_done <= w_frame_done_next;
    end
  end

  // Next-state logic; re-enable during drain wins over reaching empty
  always_comb begin
    w_state_next      = r_state;
    w_frame_done_next = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.output_buffer_enable) w_state_next = COLLECT;
      end
      COLLECT: begin
        if (!bus.output_buffer_enable) w_state_next = DRAIN;
      end
      DRAIN: begin
        if (bus.output_buffer_enable) begin
          w_state_next = COLLECT;
        end else if (w_count_next == '0) begin
          w_state_next      = IDLE;
          w_frame_done_next = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= w_wr_word;
  end

  // Pointers, occupancy and registered flags, all updated on the same edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
      r_full  <= (w_count_next == FULL_CNT);
      r_empty <= (w_count_next == '0);
    end
  end

  // Registered read port; rd_data holds its last value between reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_ok;
      if (w_rd_ok) r_rd_data <= r_mem[r_rd_ptr];
    end
  end

  // Sticky overflow flag, cleared only by reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overflow <= 1'b0;
    end else if (w_wr_drop) begin
      r_overflow <= 1'b1;
    end
  end

  assign bus.rd_data    = r_rd_data;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.full       = r_full;
  assign bus.empty      = r_empty;
  assign bus.count      = r_count;
  assign bus.overflow   = r_overflow;
  assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_output_buffer.sv
// tb/tb_output_buffer.sv - directed self-checking bench for output_buffer
module tb_output_buffer;
  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_errors;

  output_buffer_if #(.DATA_WIDTH(32), .DEPTH(16)) bus ();

  output_buffer #(.DATA_WIDTH(32), .DEPTH(16)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_count"},      32'(bus.count),      32'd0);
    check({tag, "_empty"},      32'(bus.empty),      32'd1);
    check({tag, "_full"},       32'(bus.full),       32'd0);
    check({tag, "_rd_valid"},   32'(bus.rd_valid),   32'd0);
    check({tag, "_rd_data"},    bus.rd_data,         32'd0);
    check({tag, "_overflow"},   32'(bus.overflow),   32'd0);
    check({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
  endtask

  initial begin
    logic [31:0] relu_exp;
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    bus.output_buffer_enable = 1'b0;
    bus.pe_result_valid      = 1'b0;
    bus.pe_result_data       = '0;
    bus.rd_en                = 1'b0;

    // Reset state
    step();
    step();
    check_reset_outputs("reset");
    reset_n = 1'b1;
    step();

    // Four words collected, then drained in order with one frame_done
    bus.output_buffer_enable = 1'b1;
    step();
    bus.pe_result_valid = 1'b1;
    bus.pe_result_data = 32'h11; step();
    bus.pe_result_data = 32'h22; step();
    bus.pe_result_data = 32'h33; step();
    bus.pe_result_data = 32'h44; step();
    bus.pe_result_valid = 1'b0;
    check("four_count", 32'(bus.count), 32'd4);
    bus.output_buffer_enable = 1'b0;
    bus.rd_en = 1'b1;
    step();
    check("rd0_data",  bus.rd_data, 32'h11);
    check("rd0_valid", 32'(bus.rd_valid), 32'd1);
    step();
    check("rd1_data",  bus.rd_data, 32'h22);
    step();
    check("rd2_data",  bus.rd_data, 32'h33);
    check("rd2_no_done", 32'(bus.frame_done), 32'd0);
    step();
    check("rd3_data",  bus.rd_data, 32'h44);
    check("rd3_done",  32'(bus.frame_done), 32'd1);
    check("rd3_empty", 32'(bus.empty), 32'd1);
    bus.rd_en = 1'b0;
    step();
    check("done_pulse_end", 32'(bus.frame_done), 32'd0);
    check("hold_valid",     32'(bus.rd_valid),   32'd0);
    check("hold_data",      bus.rd_data,         32'h44);

    // Read while empty is ignored
    bus.rd_en = 1'b1;
    step();
    check("rd_empty_valid", 32'(bus.rd_valid), 32'd0);
    check("rd_empty_count", 32'(bus.count),    32'd0);
    check("rd_empty_data",  bus.rd_data,       32'h44);
    bus.rd_en = 1'b0;

    // Valid in IDLE is ignored and does not set overflow
    bus.pe_result_valid = 1'b1;
    bus.pe_result_data  = 32'h55;
    step();
    bus.pe_result_valid = 1'b0;
    check("idle_wr_count", 32'(bus.count),    32'd0);
    check("idle_wr_ovf",   32'(bus.overflow), 32'd0);

    // Seventeen writes into a 16-deep buffer
    bus.output_buffer_enable = 1'b1;
    step();
    bus.pe_result_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.pe_result_data = 32'(256 + i);
      step();
    end
    check("fill_full",  32'(bus.full),     32'd1);
    check("fill_count", 32'(bus.count),    32'd16);
    check("fill_ovf0",  32'(bus.overflow), 32'd0);
    bus.pe_result_data = 32'h111;
    step();
    bus.pe_result_valid = 1'b0;
    check("ovf_set",   32'(bus.overflow), 32'd1);
    check("ovf_count", 32'(bus.count),    32'd16);
    bus.output_buffer_enable = 1'b0;
    bus.rd_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("drain16_%0d", i), bus.rd_data, 32'(256 + i));
    end
    check("drain16_done", 32'(bus.frame_done), 32'd1);
    bus.rd_en = 1'b0;
    step();
    check("drain16_empty",  32'(bus.empty),    32'd1);
    check("drain16_no17th", 32'(bus.rd_valid), 32'd0);
    check("ovf_sticky",     32'(bus.overflow), 32'd1);

    // Simultaneous read and write keep count at 5 and preserve order
    bus.output_buffer_enable = 1'b1;
    step();
    bus.pe_result_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.pe_result_data = 32'(32'h201 + i);
      step();
    end
    check("five_count", 32'(bus.count), 32'd5);
    bus.rd_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.pe_result_data = 32'(32'h206 + i);
      step();
      check($sformatf("rw_data_%0d", i),  bus.rd_data,     32'(32'h201 + i));
      check($sformatf("rw_count_%0d", i), 32'(bus.count),  32'd5);
    end
    bus.rd_en = 1'b0;
    bus.pe_result_data = 32'h210; step();
    bus.pe_result_data = 32'h211; step();
    bus.pe_result_valid = 1'b0;
    check("seven_count", 32'(bus.count), 32'd7);

    // Reset in the middle of DRAIN discards data and gives no frame_done
    bus.output_buffer_enable = 1'b0;
    step();
    check("drain7_count", 32'(bus.count), 32'd7);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_count",    32'(bus.count),    32'd0);
    check("midrst_empty",    32'(bus.empty),    32'd1);
    check("midrst_rd_data",  bus.rd_data,       32'd0);
    check("midrst_ovf",      32'(bus.overflow), 32'd0);
    step();
    check("midrst_no_done",  32'(bus.frame_done), 32'd0);
    reset_n = 1'b1;
    step();
    check("postrst_no_done", 32'(bus.frame_done), 32'd0);
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
    check("postrst_discard", 32'(bus.rd_valid), 32'd0);
    check("postrst_count",   32'(bus.count),    32'd0);

    // Negative word handling (ReLU when enabled, bit-exact otherwise)
`ifdef OUTPUT_BUFFER_RELU_EN
    relu_exp = 32'h0000_0000;
`else
    relu_exp = 32'hFFFF_FFF6;
`endif
    bus.output_buffer_enable = 1'b1;
    step();
    bus.pe_result_valid = 1'b1;
    bus.pe_result_data = 32'hFFFF_FFF6; step();
    bus.pe_result_data = 32'h0000_000A; step();
    bus.pe_result_valid = 1'b0;
    bus.output_buffer_enable = 1'b0;
    bus.rd_en = 1'b1;
    step();
    check("neg_word", bus.rd_data, relu_exp);
    step();
    check("pos_word", bus.rd_data, 32'h0000_000A);
    check("neg_done", 32'(bus.frame_done), 32'd1);
    bus.rd_en = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/output_buffer.md
OUTPUT_BUFFER -- requirements
Module: output_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of one PE-array result word (signed two's complement).
REQ-002 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, >= 4.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port output_buffer_enable  input  1  collect enable from control unit.
REQ-006 SHALL have port pe_result_valid  input  1  PE-array result word present this cycle.
REQ-007 SHALL have port pe_result_data  input  DATA_WIDTH  PE-array result word.
REQ-008 SHALL have port rd_en  input  1  host read request.
REQ-009 SHALL have port rd_data  output  DATA_WIDTH  read word, registered.
REQ-010 SHALL have port rd_valid  output  1  rd_data holds a valid word this cycle.
REQ-011 SHALL have port full / empty  output  1 each  occupancy == DEPTH / == 0.
REQ-012 SHALL have port count  output  log2(DEPTH)+1  current occupancy.
REQ-013 SHALL have port overflow  output  1  sticky: a write was dropped.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse at end of drain.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, COLLECT, DRAIN.
REQ-016 IDLE -> COLLECT on the first edge output_buffer_enable = 1.
REQ-017 COLLECT -> DRAIN on the first edge output_buffer_enable = 0.
REQ-018 DRAIN -> IDLE on the edge where occupancy becomes 0 (or is 0 on entry); frame_done = 1 for exactly that following cycle.
REQ-019 DRAIN -> COLLECT if output_buffer_enable returns to 1 before empty; no frame_done.
REQ-020 Write accepted iff state == COLLECT, pe_result_valid = 1, and not full; pe_result_valid in IDLE/DRAIN is ignored without setting overflow.
REQ-021 In COLLECT, pe_result_valid = 1 while full drops the word and sets overflow; overflow clears only on reset.
REQ-022 Read accepted iff rd_en = 1 and not empty, in any state; rd_en while empty ignored, rd_valid = 0.
REQ-023 Read latency 1 cycle: accepted read at edge N -> rd_data/rd_valid valid after edge N; rd_data holds last value when rd_valid = 0.
REQ-024 Simultaneous accepted read and write: both performed, count unchanged; write while full is not rescued by a same-cycle read (dropped).
REQ-025 Read and write while empty: write accepted, read ignored (no fall-through).
REQ-026 Pointers SHALL wrap modulo DEPTH; count ranges 0..DEPTH.
REQ-027 full, empty, count SHALL be registered, consistent with the same edge's pointer update.

Reset
REQ-028 reset_n = 0 SHALL asynchronously force state IDLE, pointers 0, count 0, empty 1, full 0, rd_valid 0, rd_data 0, overflow 0, frame_done 0.
REQ-029 Reset mid-COLLECT or mid-DRAIN SHALL discard all stored words; no frame_done.
REQ-030 Deassertion SHALL be taken synchronously at the next rising edge; first write possible on the edge after.

Configuration
REQ-031 Macro OUTPUT_BUFFER_RELU_EN defined: each accepted word with sign bit 1 SHALL be stored as 0 (ReLU on write); non-negative words stored unchanged.
REQ-032 Macro OUTPUT_BUFFER_RELU_EN undefined: words SHALL be stored bit-exact; no other behaviour differs.

Verification
REQ-033 Reset then enable=1, 4 valid words 0x11,0x22,0x33,0x44 -> count = 4; enable=0, rd_en 4 cycles -> rd_data 0x11..0x44 in order, frame_done pulses once after 4th read.
REQ-034 DEPTH=16, 17 valid words in COLLECT without reads -> full = 1, count = 16, overflow = 1, 17th word absent on drain.
REQ-035 count = 5, write and read same cycle for 10 cycles -> count stays 5, data order preserved.
REQ-036 rd_en = 1 while empty -> rd_valid = 0, count = 0, pointers unchanged.
REQ-037 count = 7 in DRAIN, reset_n pulsed low mid-cycle -> outputs at reset values immediately, no frame_done.
REQ-038 With OUTPUT_BUFFER_RELU_EN, write 0xFFFFFFF6 and 0x0000000A -> read 0x00000000 then 0x0000000A; without macro -> 0xFFFFFFF6 then 0x0000000A.
